// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers; Busy spans the modelled mult/div latency.
// Define MDU_MADD_EN to add madd/maddu (ops 7/8), which accumulate the product into {HI,LO}.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MFRSE,
  input  logic [31:0] MFRTE,
  input  logic [3:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic [3:0]    op_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic [31:0]   hi_d;
  logic [31:0]   lo_d;
  logic          is_mul;
  logic          is_div;
  logic          accept;
  logic          done;
  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic [31:0]   quot_s;
  logic [31:0]   rem_s;
  logic [31:0]   quot_u;
  logic [31:0]   rem_u;

  always_comb begin
    is_mul = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
`ifdef MDU_MADD_EN
    is_mul = is_mul || (MDOp == OP_MADD) || (MDOp == OP_MADDU);
`endif
    is_div = (MDOp == OP_DIV) || (MDOp == OP_DIVU);
  end

  assign accept = (state == IDLE) && Start && (is_mul || is_div);
  assign done   = (state == RUN) && (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (done)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Arithmetic always works on the operands captured at Start.
  assign prod_s = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
  assign prod_u = {32'd0, op_a} * {32'd0, op_b};

  always_comb begin
    // Most-negative / -1 overflows 32-bit signed division; pin it to the architectural answer.
    if ((op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF)) begin
      quot_s = 32'h8000_0000;
      rem_s  = 32'd0;
    end else begin
      quot_s = $signed(op_a) / $signed(op_b);
      rem_s  = $signed(op_a) % $signed(op_b);
    end
    quot_u = op_a / op_b;
    rem_u  = op_a % op_b;
  end

  always_comb begin
    Busy = (state == RUN);
    hi_d = hi_q;
    lo_d = lo_q;
    if (state == IDLE) begin
      if (MDOp == OP_MTHI) hi_d = MFRSE;
      if (MDOp == OP_MTLO) lo_d = MFRSE;
    end else if (done) begin
      case (op_q)
        OP_MULT:  {hi_d, lo_d} = prod_s;
        OP_MULTU: {hi_d, lo_d} = prod_u;
        OP_DIV:   if (op_b != 32'd0) begin
                    hi_d = rem_s;
                    lo_d = quot_s;
                  end
        OP_DIVU:  if (op_b != 32'd0) begin
                    hi_d = rem_u;
                    lo_d = quot_u;
                  end
`ifdef MDU_MADD_EN
        OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
        OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      op_a <= '0;
      op_b <= '0;
      op_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (accept) begin
        cnt  <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        op_a <= MFRSE;
        op_b <= MFRTE;
        op_q <= MDOp;
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule
